// File: rtl/floating_point_misc_scheduler.sv
// floating_point_misc_scheduler
// Shares one combinational FP misc datapath (FMV / FCLASS / FSGNJ / FSGNJN /
// FSGNJX) between NUM_REQ requesters through a round-robin arbiter and a
// two-stage valid/ready pipeline (S1 = granted operands, S2 = result).
// Optional feature macro: FMISC_SCHEDULER_PERF_EN (per-requester grant
// counters and a writeback stall counter, all saturating).
// Operation encoding: 0 FMV, 1 FCLASS, 2 FSGNJ, 3 FSGNJN, 4 FSGNJX, others undefined.
// FCLASS code: 0 -inf, 1 -normal, 2 -subnormal, 3 -zero, 4 +zero,
//              5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
module floating_point_misc_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 6,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*32-1:0]    req_operand_i,
    input  logic [NUM_REQ-1:0]       req_sign_inject_i,
    input  logic [NUM_REQ*3-1:0]     req_operation_i,
    input  logic [NUM_REQ-1:0]       req_dest_reg_file_i,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
    input  logic                     wb_ready_i,
    output logic                     wb_valid_o,
    output logic [31:0]              wb_result_o,
    output logic                     wb_dest_reg_file_o,
    output logic [TAG_W-1:0]         wb_tag_o,
    output logic [SRC_W-1:0]         wb_source_o,
    output logic                     busy_o
`ifdef FMISC_SCHEDULER_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]    perf_grant_count_o,
    output logic [31:0]              perf_stall_count_o
`endif
);

    localparam logic [2:0] OP_FMV    = 3'd0;
    localparam logic [2:0] OP_FCLASS = 3'd1;
    localparam logic [2:0] OP_FSGNJ  = 3'd2;
    localparam logic [2:0] OP_FSGNJN = 3'd3;
    localparam logic [2:0] OP_FSGNJX = 3'd4;

    // IEEE-754 single-precision classification into a 4-bit code.
    function automatic logic [3:0] fclass_code(input logic [31:0] x);
        logic [3:0] code;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) begin
                code = x[31] ? 4'd0 : 4'd7;
            end else begin
                code = x[22] ? 4'd9 : 4'd8;
            end
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0) begin
                code = x[31] ? 4'd3 : 4'd4;
            end else begin
                code = x[31] ? 4'd2 : 4'd5;
            end
        end else begin
            code = x[31] ? 4'd1 : 4'd6;
        end
        return code;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_operand_q, s1_operand_d;
    logic             s1_inj_q, s1_inj_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_dest_q, s1_dest_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [SRC_W-1:0] s1_src_q, s1_src_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_result_q, s2_result_d;
    logic             s2_dest_q, s2_dest_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [SRC_W-1:0] s2_src_q, s2_src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             advance1_s, advance2_s, transfer_s, found_s;
    logic [SRC_W-1:0] grant_idx_s, cand_s;
    logic [31:0]      dp_result_s;
    logic             dp_dest_s;

    assign advance2_s = !s2_valid_q | wb_ready_i;
    assign advance1_s = !s1_valid_q | advance2_s;
    assign transfer_s = found_s & advance1_s & !flush_i;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = {SRC_W{1'b0}};
        cand_s      = {SRC_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = SRC_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found_s && req_valid_i[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                found_s     = found_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // One-hot ready on the granted requester when S1 can accept.
    always_comb begin
        req_ready_o = {NUM_REQ{1'b0}};
        if (transfer_s) begin
            req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            req_ready_o = {NUM_REQ{1'b0}};
        end
    end

    // Shared datapath evaluated on the S1 contents.
    always_comb begin
        dp_result_s = 32'd0;
        dp_dest_s   = s1_dest_q;
        case (s1_op_q)
            OP_FMV: begin
                dp_result_s = s1_operand_q;
                dp_dest_s   = !s1_dest_q;
            end
            OP_FCLASS: dp_result_s = {28'd0, fclass_code(s1_operand_q)};
            OP_FSGNJ:  dp_result_s = {s1_inj_q, s1_operand_q[30:0]};
            OP_FSGNJN: dp_result_s = {!s1_inj_q, s1_operand_q[30:0]};
            OP_FSGNJX: dp_result_s = {s1_inj_q ^ s1_operand_q[31], s1_operand_q[30:0]};
            default: begin
                dp_result_s = 32'd0;
                dp_dest_s   = s1_dest_q;
            end
        endcase
    end

    // Next-state for pointer, S1 and S2 (flush wins over everything).
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        s1_valid_d   = s1_valid_q;
        s1_operand_d = s1_operand_q;
        s1_inj_d     = s1_inj_q;
        s1_op_d      = s1_op_q;
        s1_dest_d    = s1_dest_q;
        s1_tag_d     = s1_tag_q;
        s1_src_d     = s1_src_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_dest_d    = s2_dest_q;
        s2_tag_d     = s2_tag_q;
        s2_src_d     = s2_src_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (transfer_s) begin
                s1_valid_d = 1'b1;
                s1_src_d   = grant_idx_s;
                rr_ptr_d   = (grant_idx_s == SRC_W'(NUM_REQ - 1)) ? {SRC_W{1'b0}}
                                                                  : grant_idx_s + SRC_W'(1);
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (SRC_W'(k) == grant_idx_s) begin
                        s1_operand_d = req_operand_i[k*32 +: 32];
                        s1_inj_d     = req_sign_inject_i[k];
                        s1_op_d      = req_operation_i[k*3 +: 3];
                        s1_dest_d    = req_dest_reg_file_i[k];
                        s1_tag_d     = req_tag_i[k*TAG_W +: TAG_W];
                    end else begin
                        s1_operand_d = s1_operand_d;
                    end
                end
            end else if (advance1_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (advance2_s) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_d = dp_result_s;
                    s2_dest_d   = dp_dest_s;
                    s2_tag_d    = s1_tag_q;
                    s2_src_d    = s1_src_q;
                end else begin
                    s2_result_d = s2_result_q;
                end
            end else begin
                s2_valid_d = s2_valid_q;
            end
        end
    end

    // Pipeline and pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_q     <= {SRC_W{1'b0}};
            s1_valid_q   <= 1'b0;
            s1_operand_q <= 32'd0;
            s1_inj_q     <= 1'b0;
            s1_op_q      <= 3'd0;
            s1_dest_q    <= 1'b0;
            s1_tag_q     <= {TAG_W{1'b0}};
            s1_src_q     <= {SRC_W{1'b0}};
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 32'd0;
            s2_dest_q    <= 1'b0;
            s2_tag_q     <= {TAG_W{1'b0}};
            s2_src_q     <= {SRC_W{1'b0}};
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_operand_q <= s1_operand_d;
            s1_inj_q     <= s1_inj_d;
            s1_op_q      <= s1_op_d;
            s1_dest_q    <= s1_dest_d;
            s1_tag_q     <= s1_tag_d;
            s1_src_q     <= s1_src_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_dest_q    <= s2_dest_d;
            s2_tag_q     <= s2_tag_d;
            s2_src_q     <= s2_src_d;
        end
    end

    assign wb_valid_o         = s2_valid_q;
    assign wb_result_o        = s2_result_q;
    assign wb_dest_reg_file_o = s2_dest_q;
    assign wb_tag_o           = s2_tag_q;
    assign wb_source_o        = s2_src_q;
    assign busy_o             = s1_valid_q | s2_valid_q;

`ifdef FMISC_SCHEDULER_PERF_EN
    logic [NUM_REQ*32-1:0] perf_grant_q, perf_grant_d;
    logic [31:0]           perf_stall_q, perf_stall_d;

    // Saturating counters; flush does not touch them.
    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready_o[k] && req_valid_i[k] &&
                (perf_grant_q[k*32 +: 32] != 32'hFFFF_FFFF)) begin
                perf_grant_d[k*32 +: 32] = perf_grant_q[k*32 +: 32] + 32'd1;
            end else begin
                perf_grant_d[k*32 +: 32] = perf_grant_q[k*32 +: 32];
            end
        end
        if (s2_valid_q && !wb_ready_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_grant_q <= {(NUM_REQ*32){1'b0}};
            perf_stall_q <= 32'd0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_count_o = perf_grant_q;
    assign perf_stall_count_o = perf_stall_q;
`endif

endmodule
